// File: rtl/disp_pkg.sv
// Shared seven-segment display constants: active-low segment patterns,
// anode/decimal-point polarity and digit index width.
package disp_pkg;

  localparam int DIG_W   = 2;
  localparam int NUM_DIG = 4;

  // Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit)
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIG-1:0] AN_ALL_OFF = 4'b1111;
  localparam logic [NUM_DIG-1:0] AN_ONE_ON  = 4'b0001;
  localparam logic               DP_OFF     = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes (10-15) show a dash so a corrupted count is visible.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with blink, hour-tens
// leading-zero blanking and per-slot anode dead-time; outputs registered.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int DEAD       = 4,
  parameter int BLINK_HALF = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_HALF);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_DEAD  = SCAN_W'(DEAD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [DIG_W-1:0]   IDX_HTENS  = DIG_W'(3);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DIG_W-1:0]   idx_q, idx_d;
  logic               phase_q, phase_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0] d_sel;
  logic [6:0] seg_dec;
  logic       scan_wrap, blink_wrap, digit_off;

  seg7_decode u_dec (
    .bcd (d_sel),
    .seg (seg_dec)
  );

  always_comb begin
    d_sel = d0;
    case (idx_q)
      2'd0:    d_sel = d0;
      2'd1:    d_sel = d1;
      2'd2:    d_sel = d2;
      default: d_sel = d3;
    endcase
  end

  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_LAST);
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d       = scan_wrap ? idx_q + 1'b1 : idx_q;
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = blink_wrap ? ~phase_q : phase_q;

    // Dead-time, blink-off half and leading-zero blanking all force the slot dark
    digit_off = (scan_cnt_q < SCAN_DEAD)
              || (phase_q && blink_mask[idx_q])
              || ((idx_q == IDX_HTENS) && blank_lz && (d3 == 4'd0));

    an_d  = AN_ALL_OFF;
    seg_d = SEG_BLANK;
    dp_d  = DP_OFF;
    if (!digit_off) begin
      an_d  = ~(AN_ONE_ON << idx_q);
      seg_d = seg_dec;
      dp_d  = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      an_q        <= AN_ALL_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= DP_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random inputs, checked
// against a model that derives slot/phase from elapsed cycles since reset.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int DT = 2;
  localparam int BH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] blink_mask = '0, dp_mask = '0;
  logic       blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run    = 0;
  int tests_failed = 0;
  int n            = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DT), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, obs, exp);
    end
  endtask

  // Expected display for the edge that ends n cycles after reset release
  task automatic model(output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
    int pos, slot, ph;
    logic [3:0] dv [4];
    logic off;
    pos  = n % SD;
    slot = (n / SD) % 4;
    ph   = (n / BH) % 2;
    dv   = '{d0, d1, d2, d3};
    off  = (pos < DT) || (ph == 1 && blink_mask[slot])
        || (slot == 3 && blank_lz && d3 == 4'd0);
    if (off) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << slot);
      e_seg = seg_tab[dv[slot]];
      e_dp  = ~dp_mask[slot];
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    model(e_an, e_seg, e_dp);
    n++;
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("an_onehot", ($countones(~an) <= 1), 1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_an"}, an, 4'b1111);
    chk({tag, "_seg"}, seg, 7'b1111111);
    chk({tag, "_dp"}, dp, 1'b1);
  endtask

  initial begin
    int first_on;
    // Reset held with all-zero digits
    repeat (3) @(negedge clk);
    check_blank("rst_hold");
    rst = 1'b0;
    n   = 0;

    // First lit digit-0 edge must be the third edge after release
    first_on = -1;
    for (int i = 0; i < 2 * SD; i++) begin
      step();
      if (first_on < 0 && an == 4'b1110) first_on = n;
    end
    chk("first_on_edge", first_on, DT + 1);

    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    run(4 * SD * 2);

    d3 = 4'd0; blank_lz = 1'b1;
    run(4 * SD * 2);
    blank_lz = 1'b0;
    run(4 * SD * 2);

    blink_mask = 4'b0011;
    run(4 * BH);
    blink_mask = 4'b0000;

    d0 = 4'hB; dp_mask = 4'b0001;
    run(4 * SD * 2);
    dp_mask = 4'b0000;

    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(7) == 0) begin
        d0 = 4'($urandom); d1 = 4'($urandom);
        d2 = 4'($urandom); d3 = 4'($urandom_range(2));
        blink_mask = 4'($urandom); dp_mask = 4'($urandom);
        blank_lz = 1'($urandom);
      end
    end

    // Mid-slot-2 asynchronous reset, bounded to one frame
    d3 = 4'd1; blink_mask = 4'b0000; blank_lz = 1'b0;
    for (int i = 0; i < 4 * SD && !((n % SD) == 4 && ((n / SD) % 4) == 2); i++) step();
    chk("slot2_reached", an, 4'b1011);
    #2 rst = 1'b1;
    #1 check_blank("rst_async");
    repeat (2) @(negedge clk);
    check_blank("rst_mid_hold");
    rst = 1'b0;
    n   = 0;
    run(4 * SD * 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
